// File: rtl/instaweb_tx_framer.sv
// instaweb_tx_framer: batch FIFO feeding a preamble/payload/parity/gap serializer onto 8 optical lanes
module instaweb_tx_framer #(
    parameter int BATCH_SIZE   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PREAMBLE_LEN = 8,
    parameter int GAP_LEN      = 2
) (
    input  logic                        clk_2g,
    input  logic                        rst_n,
    input  logic [BATCH_SIZE-1:0]       s_batch_data,
    input  logic [7:0]                  s_batch_lanes,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [7:0]                  optical_tx,
    output logic                        tx_active,
    output logic                        batch_sent,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;
    localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int MAX_PB  = (BATCH_SIZE > PREAMBLE_LEN) ? BATCH_SIZE : PREAMBLE_LEN;
    localparam int MAX_LEN = (MAX_PB > GAP_LEN) ? MAX_PB : GAP_LEN;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] PAY_LAST = CW'(BATCH_SIZE - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PARITY, GAP} state_t;

    logic [BATCH_SIZE+7:0] mem [FIFO_DEPTH];
    logic [BATCH_SIZE+7:0] head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         count;
    logic                  push, pop, fifo_empty;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BATCH_SIZE-1:0] shift_q, shift_n;
    logic [7:0]            lanes_q, lanes_n;
    logic                  par_q, par_n;
    logic [7:0]            tx_n;
    logic                  active_n, sent_n;

    assign s_ready    = rst_n && (count < LW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign fifo_empty = (count == '0);
    assign fifo_level = count;
    assign head       = mem[rd_ptr];

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_2g) begin
        if (push) mem[wr_ptr] <= {s_batch_lanes, s_batch_data};
    end

    // FIFO pointers and occupancy; push and pop in one cycle cancel out
    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + LW'(push) - LW'(pop);
        end
    end

    // Next state plus the symbol to drive next; outputs are computed one step ahead so they register in line with the state
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shift_n  = shift_q;
        lanes_n  = lanes_q;
        par_n    = par_q;
        tx_n     = '0;
        active_n = 1'b0;
        sent_n   = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: pop = !fifo_empty;
            PREAMBLE: begin
                active_n = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_n = PAYLOAD;
                    cnt_n   = '0;
                    tx_n    = lanes_q & {8{shift_q[0]}};
                end else begin
                    cnt_n = cnt + CW'(1);
                    tx_n  = lanes_q & {8{cnt[0]}};
                end
            end
            PAYLOAD: begin
                active_n = 1'b1;
                if (cnt == PAY_LAST) begin
                    state_n = PARITY;
                    cnt_n   = '0;
                    tx_n    = lanes_q & {8{par_q}};
                    sent_n  = 1'b1;
                end else begin
                    cnt_n   = cnt + CW'(1);
                    shift_n = shift_q >> 1;
                    tx_n    = lanes_q & {8{shift_q[1]}};
                end
            end
            PARITY: begin
                active_n = 1'b1;
                state_n  = GAP;
                cnt_n    = '0;
            end
            GAP: begin
                active_n = 1'b1;
                if (cnt == GAP_LAST) begin
                    pop      = !fifo_empty;
                    state_n  = IDLE;
                    active_n = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            state_n  = PREAMBLE;
            cnt_n    = '0;
            shift_n  = head[BATCH_SIZE-1:0];
            lanes_n  = head[BATCH_SIZE+:8];
            par_n    = ^head[BATCH_SIZE-1:0];
            tx_n     = head[BATCH_SIZE+:8];
            active_n = 1'b1;
        end
    end

    // Framer state and registered line outputs; reset aborts any frame in flight
    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_q    <= '0;
            lanes_q    <= '0;
            par_q      <= 1'b0;
            optical_tx <= '0;
            tx_active  <= 1'b0;
            batch_sent <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift_q    <= shift_n;
            lanes_q    <= lanes_n;
            par_q      <= par_n;
            optical_tx <= tx_n;
            tx_active  <= active_n;
            batch_sent <= sent_n;
        end
    end
endmodule

// File: tb/tb_instaweb_tx_framer.sv
// tb_instaweb_tx_framer: directed frame vectors plus backpressure and reset corner sequences
module tb_instaweb_tx_framer;
    logic        clk_2g;
    logic        rst_n;
    logic [15:0] s_batch_data;
    logic [7:0]  s_batch_lanes;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  optical_tx;
    logic        tx_active;
    logic        batch_sent;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [15:0]      data;
        logic [7:0]       lanes;
        logic [0:15][7:0] pay;
        logic [7:0]       par;
    } vec_t;

    vec_t vecs [5];

    instaweb_tx_framer dut (
        .clk_2g(clk_2g),
        .rst_n(rst_n),
        .s_batch_data(s_batch_data),
        .s_batch_lanes(s_batch_lanes),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .optical_tx(optical_tx),
        .tx_active(tx_active),
        .batch_sent(batch_sent),
        .fifo_level(fifo_level)
    );

    initial clk_2g = 1'b0;
    always #5 clk_2g = ~clk_2g;
    always @(posedge clk_2g) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] l, output int at);
        int w = 0;
        s_batch_data  = d;
        s_batch_lanes = l;
        s_valid       = 1'b1;
        while (!s_ready && w < 100) begin
            @(posedge clk_2g);
            #1;
            w++;
        end
        if (!s_ready) chk("push_timeout", 0, 1);
        @(posedge clk_2g);
        #1;
        at = edge_cnt;
        s_valid = 1'b0;
    endtask

    task automatic check_frame(input int v);
        logic [7:0] etx;
        @(negedge clk_2g);
        chk("idle_before_frame", int'(tx_active), 0);
        for (int k = 0; k < 27; k++) begin
            @(negedge clk_2g);
            if (k < 8) etx = (k % 2 == 0) ? vecs[v].lanes : 8'h00;
            else if (k < 24) etx = vecs[v].pay[k-8];
            else if (k == 24) etx = vecs[v].par;
            else etx = 8'h00;
            chk($sformatf("v%0d_tx_k%0d", v, k), int'(optical_tx), int'(etx));
            chk($sformatf("v%0d_active_k%0d", v, k), int'(tx_active), 1);
            chk($sformatf("v%0d_sent_k%0d", v, k), int'(batch_sent), (k == 24) ? 1 : 0);
        end
        @(negedge clk_2g);
        chk("active_after_frame", int'(tx_active), 0);
        chk("tx_after_frame", int'(optical_tx), 0);
    endtask

    initial begin
        int at;
        int acc [6];
        vecs[0] = '{16'hA5C3, 8'h0F,
                    {8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F,
                     8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h0F}, 8'h00};
        vecs[1] = '{16'h0001, 8'hFF, {8'hFF, {15{8'h00}}}, 8'hFF};
        vecs[2] = '{16'hFFFF, 8'h00, '0, 8'h00};
        vecs[3] = '{16'h8000, 8'h81, {{15{8'h00}}, 8'h81}, 8'h81};
        vecs[4] = '{16'h0003, 8'h3C, {8'h3C, 8'h3C, {14{8'h00}}}, 8'h00};

        rst_n = 1'b0;
        s_valid = 1'b0;
        s_batch_data = '0;
        s_batch_lanes = '0;
        repeat (3) @(posedge clk_2g);
        #1;
        chk("rst_tx", int'(optical_tx), 0);
        chk("rst_active", int'(tx_active), 0);
        chk("rst_sent", int'(batch_sent), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'(s_ready), 0);
        @(negedge clk_2g);
        rst_n = 1'b1;
        #1;
        chk("release_ready", int'(s_ready), 1);
        chk("release_tx", int'(optical_tx), 0);
        repeat (3) @(negedge clk_2g);
        rst_n = 1'b0;
        #1;
        chk("idle_rst_ready", int'(s_ready), 0);
        chk("idle_rst_tx", int'(optical_tx), 0);
        chk("idle_rst_level", int'(fifo_level), 0);
        @(negedge clk_2g);
        rst_n = 1'b1;
        @(negedge clk_2g);

        for (int v = 0; v < 5; v++) begin
            push(vecs[v].data, vecs[v].lanes, at);
            check_frame(v);
        end

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(16'h0001 << i, 8'hFF, acc[i]);
                    if (i == 4) begin
                        chk("bp_level_full", int'(fifo_level), 4);
                        chk("bp_ready_full", int'(s_ready), 0);
                    end
                end
                chk("bp_first_five_back_to_back", acc[4] - acc[0], 4);
                chk("bp_sixth_stall", acc[5] - acc[4], 25);
            end
            begin
                int w = 0;
                int low = 0;
                int sent = 0;
                @(negedge clk_2g);
                while (!tx_active && w < 10) begin
                    @(negedge clk_2g);
                    w++;
                end
                chk("bp_start", int'(tx_active), 1);
                for (int c = 0; c < 162; c++) begin
                    if (c > 0) @(negedge clk_2g);
                    if (!tx_active) low++;
                    if (batch_sent) sent++;
                    if (c % 27 == 0) chk($sformatf("bp_pre0_c%0d", c), int'(optical_tx), 8'hFF);
                    if (c % 27 == 24) chk($sformatf("bp_par_c%0d", c), int'(optical_tx), 8'hFF);
                end
                chk("bp_active_gaps", low, 0);
                chk("bp_sent_count", sent, 6);
                @(negedge clk_2g);
                chk("bp_idle_after", int'(tx_active), 0);
            end
        join

        @(negedge clk_2g);
        push(16'hFFFF, 8'hFF, at);
        push(16'h1234, 8'h11, at);
        repeat (14) @(negedge clk_2g);
        chk("mid_payload5_tx", int'(optical_tx), 8'hFF);
        chk("mid_level", int'(fifo_level), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", int'(optical_tx), 0);
        chk("mid_rst_active", int'(tx_active), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_ready", int'(s_ready), 0);
        @(negedge clk_2g);
        chk("mid_rst_sent", int'(batch_sent), 0);
        rst_n = 1'b1;
        @(negedge clk_2g);
        push(vecs[0].data, vecs[0].lanes, at);
        check_frame(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/instaweb_tx_framer.md
# instaweb_tx_framer

Symbol-synchronous optical transmit framer for an InstaWeb originating node. It accepts 16-symbol batches with a per-batch lane mask over a valid/ready handshake and buffers them in a small FIFO. Each batch is serialized as a framed burst (preamble, payload, parity, gap) onto the 8 OWC transmit lanes. It feeds the batched receive path of downstream relays, so every frame carries exactly BATCH_SIZE payload symbols.

## Interface

- BATCH_SIZE, 16, payload symbols per frame.
- FIFO_DEPTH, 4, buffered batches; power of two.
- PREAMBLE_LEN, 8, preamble symbols; even, ≥2.
- GAP_LEN, 2, idle symbols after parity; ≥1.

- clk_2g  in  1  symbol clock; one symbol per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- s_batch_data  in  BATCH_SIZE  batch symbols; bit 0 is sent first.
- s_batch_lanes  in  8  lane mask for this batch.
- s_valid  in  1  batch offered.
- s_ready  out  1  FIFO can accept.
- optical_tx  out  8  registered lane drive.
- tx_active  out  1  high while a frame occupies the line.
- batch_sent  out  1  one-cycle pulse per completed frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  resident FIFO entries.

## Operation

- **Handshake:** a transfer occurs on a rising edge with s_valid && s_ready.
  - s_ready = (fifo_level < FIFO_DEPTH), derived from the registered count.
  - It is forced to 0 while rst_n is low.
  - There is no bypass when full, even if a pop happens in the same cycle.
- **FIFO:** entries are {lanes, data}. A simultaneous push and pop leaves fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- **States:** IDLE → PREAMBLE → PAYLOAD → PARITY → GAP → (PREAMBLE | IDLE).
- **IDLE:** optical_tx = 0 and tx_active = 0. If the FIFO is non-empty, pop one entry into the shift and lane registers and go to PREAMBLE.
- **PREAMBLE:** lasts PREAMBLE_LEN cycles. Symbol k is 1 for even k and 0 for odd k. optical_tx = lanes & {8{sym}}.
- **PAYLOAD:** lasts BATCH_SIZE cycles. Cycle i drives lanes & {8{data[i]}}.
- **PARITY:** lasts 1 cycle. The symbol is the XOR of all BATCH_SIZE data bits (even parity). batch_sent = 1 in this cycle only.
- **GAP:** lasts GAP_LEN cycles with optical_tx = 0.
  - On the last gap cycle, if the FIFO is non-empty, pop and go to PREAMBLE (no idle cycle between frames).
  - Otherwise go to IDLE.
- The lane mask is latched at pop and held for the whole frame.
- A mask of 0 still runs full frame timing: tx_active stays high and batch_sent still pulses.
- The per-state symbol counter is log2-sized, reset on every state entry, and never wraps inside a state.

## Timing

- **Reset values:** optical_tx = 0, tx_active = 0, batch_sent = 0, fifo_level = 0, s_ready = 0 while asserted. State goes to IDLE and the FIFO is emptied, all asynchronously.
- After rst_n deasserts, s_ready = 1 from the first edge.
- A batch accepted at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1. Its first preamble symbol appears on optical_tx after edge N+1.
- Frame length is PREAMBLE_LEN + BATCH_SIZE + 1 + GAP_LEN cycles (27 by default).
- tx_active and batch_sent are registered and aligned with the optical_tx symbol they describe.
- **Reset mid-frame:** the frame is aborted and optical_tx = 0 immediately. No batch_sent is issued. The next frame after release starts at preamble symbol 0.

## Test plan

- **Reset:** assert rst_n = 0 mid-idle → all outputs 0. Release → s_ready = 1 and optical_tx = 0.
- **Single frame:** push data 16'hA5C3 with lanes 8'h0F.
  - Preamble: 0F,00,0F,00,0F,00,0F,00.
  - Payload: 0F,0F,00,00,00,00,0F,0F,0F,00,0F,00,00,0F,00,0F.
  - Parity: 00, with batch_sent = 1.
  - Gap: 00,00, then tx_active = 0.
- **Parity-1 frame:** push data 16'h0001 with lanes 8'hFF → payload FF then 15×00, parity FF.
- **Backpressure:** push every cycle.
  - The first entry pops immediately; fifo_level reaches 4 after the 5th accept and s_ready = 0.
  - The 6th batch stalls until the pop at the end of frame 1's gap.
  - Frames then run back-to-back with tx_active held high and no zero-length or idle cycles between frames.
- **Zero mask:** push data 16'hFFFF with lanes 8'h00 → optical_tx = 0 for all 27 cycles, tx_active high for 27 cycles, exactly one batch_sent.
- **Reset mid-frame:** assert rst_n at payload symbol 5 → optical_tx = 0 asynchronously and fifo_level = 0. A new push after release produces a complete 27-cycle frame starting with the preamble.
